// File: rtl/doc_edit_ctrl_pkg.sv
// Shared definitions for the document editor: grid geometry, command
// opcodes from the keyboard decoder, cursor move codes and controller states.
// Reused by the keyboard decoder and the word display.
package doc_edit_ctrl_pkg;
    localparam int COLS      = 20;
    localparam int ROWS      = 15;
    localparam int DOC_DEPTH = COLS * ROWS;
    localparam int ADDR_W    = 9;
    localparam int ROW_W     = 4;
    localparam int COL_W     = 5;
    localparam logic [7:0] BLANK = 8'h20;

    typedef enum logic [2:0] {
        OP_CHAR      = 3'd0,
        OP_BACKSPACE = 3'd1,
        OP_NEWLINE   = 3'd2,
        OP_LEFT      = 3'd3,
        OP_RIGHT     = 3'd4,
        OP_UP        = 3'd5,
        OP_DOWN      = 3'd6,
        OP_CLEAR     = 3'd7
    } cmd_op_e;

    typedef enum logic [3:0] {
        MV_NONE, MV_ADV, MV_RET, MV_NL,
        MV_LEFT, MV_RIGHT, MV_UP, MV_DOWN, MV_HOME
    } move_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;
endpackage

// File: rtl/doc_edit_ctrl_cursor_tracker.sv
// Cursor row/column registers for the document grid.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   move         move code applied on the next rising edge
//   row, col     current cursor position
//   addr         row*COLS+col of the current position
//   prev_addr    address of the cell before the cursor (0 when at the origin)
module doc_edit_ctrl_cursor_tracker #(
    parameter int COLS = doc_edit_ctrl_pkg::COLS,
    parameter int ROWS = doc_edit_ctrl_pkg::ROWS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  doc_edit_ctrl_pkg::move_e move,
    output logic [3:0]               row,
    output logic [4:0]               col,
    output logic [8:0]               addr,
    output logic [8:0]               prev_addr
);
    import doc_edit_ctrl_pkg::*;

    localparam logic [3:0] ROW_LAST = 4'(ROWS - 1);
    localparam logic [4:0] COL_LAST = 5'(COLS - 1);

    logic [3:0] row_d;
    logic [4:0] col_d;

    always_comb begin
        row_d = row;
        col_d = col;
        case (move)
            MV_ADV: begin
                if (col == COL_LAST) begin
                    col_d = '0;
                    row_d = (row == ROW_LAST) ? 4'd0 : row + 4'd1;
                end else begin
                    col_d = col + 5'd1;
                end
            end
            MV_RET: begin
                // At the origin the cursor stays put.
                if (col != 5'd0) begin
                    col_d = col - 5'd1;
                end else if (row != 4'd0) begin
                    col_d = COL_LAST;
                    row_d = row - 4'd1;
                end
            end
            MV_NL: begin
                col_d = '0;
                row_d = (row == ROW_LAST) ? 4'd0 : row + 4'd1;
            end
            MV_LEFT:  if (col != 5'd0)    col_d = col - 5'd1;
            MV_RIGHT: if (col != COL_LAST) col_d = col + 5'd1;
            MV_UP:    if (row != 4'd0)    row_d = row - 4'd1;
            MV_DOWN:  if (row != ROW_LAST) row_d = row + 4'd1;
            MV_HOME: begin
                row_d = '0;
                col_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row <= '0;
            col <= '0;
        end else begin
            row <= row_d;
            col <= col_d;
        end
    end

    // row*20 as row*16 + row*4; tied to the 20-column geometry.
    assign addr      = 9'({row, 4'b0000}) + 9'({row, 2'b00}) + 9'(col);
    assign prev_addr = (addr == 9'd0) ? 9'd0 : addr - 9'd1;
endmodule

// File: rtl/doc_edit_ctrl.sv
// Write-side controller for the document character RAM. Accepts editing
// commands, tracks the cursor and drives the RAM write port, including a
// full blanking sweep (optionally right after reset).
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake (ready only when idle)
//   cmd_op, cmd_char            opcode and character for CHAR
//   mem_addr/mem_din/mem_we     registered RAM write port
//   cursor_addr/row/col         cursor position for the display
module doc_edit_ctrl #(
    parameter int         COLS           = doc_edit_ctrl_pkg::COLS,
    parameter int         ROWS           = doc_edit_ctrl_pkg::ROWS,
    parameter logic [7:0] BLANK          = doc_edit_ctrl_pkg::BLANK,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_char,
    output logic [8:0] mem_addr,
    output logic [7:0] mem_din,
    output logic       mem_we,
    output logic [8:0] cursor_addr,
    output logic [3:0] cursor_row,
    output logic [4:0] cursor_col
);
    import doc_edit_ctrl_pkg::*;

    localparam logic [8:0] CLR_LAST  = 9'(COLS * ROWS - 1);
    localparam state_e     RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    state_e     state_q, state_d;
    logic [8:0] clr_q, clr_d;
    logic [8:0] addr_d;
    logic [7:0] din_d;
    logic       we_d;
    move_e      move;
    logic [8:0] prev_addr;
    cmd_op_e    op;

    assign op        = cmd_op_e'(cmd_op);
    assign cmd_ready = (state_q == ST_IDLE);

    doc_edit_ctrl_cursor_tracker #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
        .clk       (clk),
        .rst       (rst),
        .move      (move),
        .row       (cursor_row),
        .col       (cursor_col),
        .addr      (cursor_addr),
        .prev_addr (prev_addr)
    );

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        we_d    = 1'b0;
        addr_d  = mem_addr;
        din_d   = mem_din;
        move    = MV_NONE;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (op)
                        OP_CHAR: begin
                            we_d   = 1'b1;
                            addr_d = cursor_addr;
                            din_d  = cmd_char;
                            move   = MV_ADV;
                        end
                        OP_BACKSPACE: begin
                            // Blank the cell the cursor retreats onto.
                            we_d   = 1'b1;
                            addr_d = prev_addr;
                            din_d  = BLANK;
                            move   = MV_RET;
                        end
                        OP_NEWLINE: move = MV_NL;
                        OP_LEFT:    move = MV_LEFT;
                        OP_RIGHT:   move = MV_RIGHT;
                        OP_UP:      move = MV_UP;
                        OP_DOWN:    move = MV_DOWN;
                        OP_CLEAR: begin
                            state_d = ST_CLEAR;
                            clr_d   = '0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_CLEAR: begin
                we_d   = 1'b1;
                addr_d = clr_q;
                din_d  = BLANK;
                clr_d  = clr_q + 9'd1;
                if (clr_q == CLR_LAST) begin
                    state_d = ST_IDLE;
                    clr_d   = '0;
                    move    = MV_HOME;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RST_STATE;
            clr_q    <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            state_q  <= state_d;
            clr_q    <= clr_d;
            mem_we   <= we_d;
            mem_addr <= addr_d;
            mem_din  <= din_d;
        end
    end
endmodule

// File: tb/tb_doc_edit_ctrl.sv
// Self-checking bench for doc_edit_ctrl: directed steps then random commands,
// compared every cycle against a linear-address reference model.
module tb_doc_edit_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_char = 8'd0;
    logic [8:0] mem_addr;
    logic [7:0] mem_din;
    logic       mem_we;
    logic [8:0] cursor_addr;
    logic [3:0] cursor_row;
    logic [4:0] cursor_col;

    doc_edit_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_char    (cmd_char),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_we      (mem_we),
        .cursor_addr (cursor_addr),
        .cursor_row  (cursor_row),
        .cursor_col  (cursor_col)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: cursor kept as (row,col), moves derived from the
    // linear cell index where wrapping matters.
    int m_row, m_col, m_idx, m_addr, m_din;
    bit m_clear, m_we;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("cmd_ready", 32'(cmd_ready), 32'(!m_clear));
        chk("mem_we", 32'(mem_we), 32'(m_we));
        chk("mem_addr", 32'(mem_addr), m_addr);
        chk("mem_din", 32'(mem_din), m_din);
        chk("cursor_row", 32'(cursor_row), m_row);
        chk("cursor_col", 32'(cursor_col), m_col);
        chk("cursor_addr", 32'(cursor_addr), m_row * 20 + m_col);
    endtask

    task automatic model_reset();
        m_row = 0; m_col = 0; m_clear = 1'b1; m_idx = 0;
        m_we = 1'b0; m_addr = 0; m_din = 0;
    endtask

    task automatic model_edge(input bit v, input int op, input int ch);
        int lin;
        m_we = 1'b0;
        if (m_clear) begin
            m_we = 1'b1; m_addr = m_idx; m_din = 32'h20;
            m_idx++;
            if (m_idx == 300) begin
                m_clear = 1'b0; m_row = 0; m_col = 0;
            end
        end else if (v) begin
            lin = m_row * 20 + m_col;
            case (op)
                0: begin
                    m_we = 1'b1; m_addr = lin; m_din = ch;
                    lin = (lin + 1) % 300;
                    m_row = lin / 20; m_col = lin % 20;
                end
                1: begin
                    if (lin > 0) lin--;
                    m_we = 1'b1; m_addr = lin; m_din = 32'h20;
                    m_row = lin / 20; m_col = lin % 20;
                end
                2: begin m_row = (m_row + 1) % 15; m_col = 0; end
                3: if (m_col > 0)  m_col--;
                4: if (m_col < 19) m_col++;
                5: if (m_row > 0)  m_row--;
                6: if (m_row < 14) m_row++;
                default: begin m_clear = 1'b1; m_idx = 0; end
            endcase
        end
    endtask

    task automatic step(input bit v, input int op, input int ch);
        cmd_valid = v;
        cmd_op    = 3'(op);
        cmd_char  = 8'(ch);
        @(posedge clk);
        model_edge(v, op, ch);
        #1;
        check_all();
    endtask

    task automatic go(input int r, input int c);
        repeat (14) step(1'b1, 5, 0);
        repeat (19) step(1'b1, 3, 0);
        repeat (r) step(1'b1, 6, 0);
        repeat (c) step(1'b1, 4, 0);
    endtask

    initial begin
        int op;
        bit v;
        model_reset();
        #12;
        check_all();                       // reset values, sweep pending
        rst = 1'b1;
        repeat (300) step(1'b1, 0, 8'h55); // CHAR held during sweep is ignored
        step(1'b0, 0, 0);

        step(1'b1, 0, 8'h41);
        step(1'b1, 0, 8'h42);
        step(1'b0, 0, 0);

        go(0, 19);
        step(1'b1, 0, 8'h43);
        go(14, 19);
        step(1'b1, 0, 8'h44);              // last cell, wraps to origin

        go(1, 0);
        step(1'b1, 1, 0);
        go(0, 0);
        step(1'b1, 1, 0);                  // backspace at origin

        step(1'b1, 3, 0);
        step(1'b1, 5, 0);
        go(14, 5);
        step(1'b1, 6, 0);
        step(1'b1, 2, 0);
        go(3, 19);
        step(1'b1, 4, 0);

        repeat (600) begin
            v  = ($urandom_range(0, 3) != 0);
            op = $urandom_range(0, 6);
            if ($urandom_range(0, 199) == 0) op = 7;
            step(v, op, $urandom_range(0, 255));
        end

        // Bounded by the model: at most one sweep left.
        while (m_clear) step(1'b0, 0, 0);
        step(1'b1, 7, 0);
        repeat (100) step(1'b1, 0, 8'h33);
        rst = 1'b0;
        #1;
        model_reset();
        check_all();                       // abort takes effect immediately
        #3;
        rst = 1'b1;
        repeat (300) step(1'b1, 1, 0);
        step(1'b0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
